router_port_rx: RTL and testbench

//  Consumer stage attached to one 1x3-router output port (vld_outN/doutN/rd_enN); one instance per port.

---
 rtl/router_pkg.sv | 34 +++
 rtl/router_rx_skid.sv | 53 +++++
 rtl/router_port_rx.sv | 206 ++++++++++++++++++++
 tb/tb_router_port_rx.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router output-port receive path.
//   - header field widths and the router soft-reset interval
//   - receive FSM state codes
//   - skid buffer entry layout (data byte plus sop/eop markers)
//   - header field extraction helpers
package router_pkg;

  localparam int HDR_LEN_W          = 6;
  localparam int ADDR_W             = 2;
  localparam int ROUTER_SFT_RST_CYC = 30;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t S_IDLE = 3'd0;
  localparam rx_state_t S_HDR  = 3'd1;
  localparam rx_state_t S_PAY  = 3'd2;
  localparam rx_state_t S_PAR  = 3'd3;
  localparam rx_state_t S_DROP = 3'd4;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } skid_ent_t;

  function automatic logic [HDR_LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[7:ADDR_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

endpackage

// File: rtl/router_rx_skid.sv
// Two-entry valid/ready skid buffer carrying {sop, eop, data}.
// The writer must only push when an entry is free; count lets it plan reads
// ahead. The head entry is held stable until it is accepted.
// Ports:
//   clk, rst            clock, async active-low reset
//   in_valid, in_ent    write strobe and entry
//   out_valid, out_ent  head entry
//   out_ready           consumer accepts head when out_valid & out_ready
//   count               current occupancy (0..2)
module router_rx_skid
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  skid_ent_t  in_ent,
  output logic       out_valid,
  output skid_ent_t  out_ent,
  input  logic       out_ready,
  output logic [1:0] count
);

  skid_ent_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] cnt;
  logic       push;
  logic       pop;

  assign out_valid = (cnt != 2'd0);
  assign out_ent   = mem[rd_ptr];
  assign count     = cnt;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (cnt != 2'd2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_ent;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/router_port_rx.sv
// Receive stage for one 1x3-router output port. Reads packets from the port
// FIFO, checks parity and destination address, and re-emits them as a
// valid/ready byte stream with sop/eop. A watchdog forces reads before the
// router's soft reset can fire; the packet is then discarded.
// Optional build macro: ROUTER_RX_STATS_EN adds saturating packet counters.
// Ports:
//   clk, rst                    clock, async active-low reset
//   vld_out, dout, rd_en        router FIFO interface (dout valid 1 cycle after rd_en)
//   m_valid, m_data, m_sop, m_eop, m_ready   output byte stream
//   pkt_done, pkt_ok, par_err, addr_err, drop, pkt_len   per-packet status pulse
//   pkt_cnt, err_cnt, drop_cnt  statistics (ROUTER_RX_STATS_EN only)
//
// state | meaning
// IDLE  | header read not yet issued
// HDR   | header byte arriving; length/address latched
// PAY   | payload bytes arriving
// PAR   | waiting for the parity byte
// DROP  | watchdog fired; remaining bytes of the packet read and discarded
module router_port_rx
  import router_pkg::*;
#(
  parameter logic [ADDR_W-1:0] PORT_ID = 2'd0,
  parameter int                TIMEOUT = 28,
  parameter int                CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_out,
  input  logic [7:0]           dout,
  output logic                 rd_en,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  input  logic                 m_ready,
  output logic                 pkt_done,
  output logic                 pkt_ok,
  output logic                 par_err,
  output logic                 addr_err,
  output logic                 drop,
  output logic [HDR_LEN_W-1:0] pkt_len
`ifdef ROUTER_RX_STATS_EN
  ,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [CNT_W-1:0]     drop_cnt
`endif
);

  localparam int WD_W = $clog2(ROUTER_SFT_RST_CYC + 1);

  if (TIMEOUT < 2 || TIMEOUT >= ROUTER_SFT_RST_CYC || CNT_W < 1) begin : g_bad_param
    $error("router_port_rx: TIMEOUT must be 2..29 and CNT_W at least 1");
  end

  rx_state_t            state;
  logic                 rd_q;
  logic                 hdr_need;   // header read still to be issued
  logic [6:0]           rd_left;    // reads still owed after the header
  logic [6:0]           cap_left;   // captures still due; 0 means next capture is a header
  logic [7:0]           par;
  logic [HDR_LEN_W-1:0] len_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [WD_W-1:0]      wd;
  logic [1:0]           buf_cnt;

  logic                 owed;
  logic                 space;
  logic                 wd_hit;
  logic                 dropping;
  logic                 cap_hdr;
  logic                 cap_par;
  logic [6:0]           len_p1;
  skid_ent_t            in_ent;
  skid_ent_t            out_ent;

  assign owed     = hdr_need | (rd_left != 7'd0);
  // A read in flight already holds a buffer slot.
  assign space    = ({1'b0, buf_cnt} + {2'b00, rd_q}) < 3'd2;
  assign wd_hit   = (wd == WD_W'(TIMEOUT));
  assign dropping = (state == S_DROP);
  // On the watchdog hit the read is forced; its byte lands in DROP and is discarded.
  assign rd_en    = vld_out & owed & (space | dropping | wd_hit);

  assign cap_hdr  = rd_q & (cap_left == 7'd0);
  assign cap_par  = rd_q & (cap_left == 7'd1);
  assign len_p1   = {1'b0, hdr_len(dout)} + 7'd1;

  assign in_ent.sop  = cap_hdr;
  assign in_ent.eop  = cap_par;
  assign in_ent.data = dout;

  router_rx_skid u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_q & ~dropping),
    .in_ent    (in_ent),
    .out_valid (m_valid),
    .out_ent   (out_ent),
    .out_ready (m_ready),
    .count     (buf_cnt)
  );

  assign m_data = out_ent.data;
  assign m_sop  = out_ent.sop;
  assign m_eop  = out_ent.eop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      rd_q     <= 1'b0;
      hdr_need <= 1'b1;
      rd_left  <= '0;
      cap_left <= '0;
      par      <= '0;
      len_q    <= '0;
      addr_q   <= '0;
      wd       <= '0;
    end else begin
      rd_q <= rd_en;

      if (rd_en || !vld_out) wd <= '0;
      else if (!wd_hit)      wd <= wd + 1'b1;

      if (rd_en) begin
        if (hdr_need) hdr_need <= 1'b0;
        else          rd_left  <= rd_left - 7'd1;
      end else if (cap_hdr) begin
        rd_left <= len_p1;
      end
      if (cap_par) hdr_need <= 1'b1;

      if (cap_hdr) begin
        len_q    <= hdr_len(dout);
        addr_q   <= hdr_addr(dout);
        par      <= dout;
        cap_left <= len_p1;
      end else if (rd_q) begin
        cap_left <= cap_left - 7'd1;
        if (!cap_par) par <= par ^ dout;
      end

      case (state)
        S_IDLE: begin
          if (wd_hit && owed) state <= S_DROP;
          else if (rd_en)     state <= S_HDR;
        end
        S_HDR: begin
          state <= (hdr_len(dout) != '0) ? S_PAY : S_PAR;
        end
        S_PAY: begin
          if (wd_hit && owed)                 state <= S_DROP;
          else if (rd_q && cap_left == 7'd2) state <= S_PAR;
        end
        S_PAR: begin
          if (wd_hit && owed) state <= S_DROP;
          else if (cap_par)   state <= S_IDLE;
        end
        S_DROP: begin
          if (cap_par) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_done <= 1'b0;
      pkt_ok   <= 1'b0;
      par_err  <= 1'b0;
      addr_err <= 1'b0;
      drop     <= 1'b0;
      pkt_len  <= '0;
    end else begin
      pkt_done <= cap_par;
      if (cap_par) begin
        drop     <= dropping;
        par_err  <= ~dropping & (dout != par);
        addr_err <= ~dropping & (addr_q != PORT_ID);
        pkt_ok   <= ~dropping & (dout == par) & (addr_q == PORT_ID);
        pkt_len  <= len_q;
      end else begin
        drop     <= 1'b0;
        par_err  <= 1'b0;
        addr_err <= 1'b0;
        pkt_ok   <= 1'b0;
      end
    end
  end

`ifdef ROUTER_RX_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
    end else if (pkt_done) begin
      if (pkt_ok && pkt_cnt != '1)                 pkt_cnt  <= pkt_cnt + 1'b1;
      if ((par_err || addr_err) && err_cnt != '1) err_cnt  <= err_cnt + 1'b1;
      if (drop && drop_cnt != '1)                  drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
module tb_router_port_rx;
  import router_pkg::*;

  localparam logic [1:0] PORT_ID = 2'd0;
  localparam int         TIMEOUT = 28;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld_out = 1'b0;
  logic [7:0] dout = 8'h00;
  logic       m_ready = 1'b0;
  logic       rd_en, m_valid, m_sop, m_eop;
  logic       pkt_done, pkt_ok, par_err, addr_err, drop;
  logic [7:0] m_data;
  logic [5:0] pkt_len;
`ifdef ROUTER_RX_STATS_EN
  logic [15:0] pkt_cnt, err_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  router_port_rx #(.PORT_ID(PORT_ID), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vld_out(vld_out), .dout(dout), .rd_en(rd_en),
    .m_valid(m_valid), .m_data(m_data), .m_sop(m_sop), .m_eop(m_eop), .m_ready(m_ready),
    .pkt_done(pkt_done), .pkt_ok(pkt_ok), .par_err(par_err), .addr_err(addr_err),
    .drop(drop), .pkt_len(pkt_len)
`ifdef ROUTER_RX_STATS_EN
    , .pkt_cnt(pkt_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Router FIFO model and expected streams.
  logic [7:0] fifo_q[$];
  logic [9:0] exp_b[$];   // {sop, eop, data}
  logic [9:0] exp_r[$];   // {ok, par_err, addr_err, drop, len}
  bit         rd_seen = 0;
  int         gap = 0;
  int         max_gap = 0;
  int         rdy_mode = 0;   // 0 always ready, 1 random, 2 stalled
  bit         avail_mode = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (rst) begin
      if (m_valid && m_ready) begin
        if (exp_b.size() == 0) check("byte_unexpected", exp_b.size(), 1);
        else                   check("byte", {22'd0, m_sop, m_eop, m_data}, {22'd0, exp_b.pop_front()});
      end
      if (pkt_done) begin
        if (exp_r.size() == 0) check("pkt_unexpected", exp_r.size(), 1);
        else check("pkt_status", {22'd0, pkt_ok, par_err, addr_err, drop, pkt_len},
                   {22'd0, exp_r.pop_front()});
      end
      if (rd_en) check("over_read", fifo_q.size() > 0, 1);
      if (vld_out && !rd_en) gap++;
      else gap = 0;
      if (gap > max_gap) max_gap = gap;
    end
    rd_seen = rd_en && rst;
    @(posedge clk);
    #1;
    if (rd_seen && fifo_q.size() != 0) dout = fifo_q.pop_front();
    vld_out = rst && (fifo_q.size() != 0) && (avail_mode ? ($urandom_range(0, 4) != 0) : 1'b1);
    m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
  endtask

  // Builds one packet from the framing rules; fixed payload is 11,22,33,...
  // A dropped packet is expected to emit only what fits the 2-entry buffer.
  task automatic send_pkt(input int len, input logic [1:0] addr, input bit corrupt,
                          input bit fixed, input bit dropped);
    logic [7:0] b;
    logic [7:0] p;
    logic [5:0] l6;
    l6 = len[5:0];
    b  = {l6, addr};
    p  = b;
    fifo_q.push_back(b);
    exp_b.push_back({2'b10, b});
    for (int i = 0; i < len; i++) begin
      b = fixed ? 8'((i + 1) * 8'h11) : 8'($urandom_range(0, 255));
      p = p ^ b;
      fifo_q.push_back(b);
      if (!dropped || i == 0) exp_b.push_back({2'b00, b});
    end
    b = corrupt ? (p ^ 8'h0C) : p;
    fifo_q.push_back(b);
    if (dropped) begin
      exp_r.push_back({4'b0001, l6});
    end else begin
      exp_b.push_back({2'b01, b});
      exp_r.push_back({(!corrupt && addr == PORT_ID), corrupt, (addr != PORT_ID), 1'b0, l6});
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((fifo_q.size() != 0 || exp_b.size() != 0 || exp_r.size() != 0) && n < budget) begin
      cyc();
      n++;
    end
    check("drain_in_time", n < budget, 1);
    repeat (4) cyc();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {rd_en, m_valid, m_sop, m_eop, pkt_done, pkt_ok, par_err, addr_err, drop}, 0);
    check({tag, "_data"}, {m_data, pkt_len}, 0);
`ifdef ROUTER_RX_STATS_EN
    check({tag, "_stats"}, {pkt_cnt, err_cnt, drop_cnt}, 0);
`endif
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) cyc();

    // Known-good packet, then the same with a bad parity byte.
    send_pkt(3, PORT_ID, 0, 1, 0);
    drain(200);
    send_pkt(3, PORT_ID, 1, 1, 0);
    drain(200);

    // Wrong destination address is flagged but still forwarded.
    send_pkt(2, 2'd2, 0, 0, 0);
    drain(200);

    // Zero-length packet immediately followed by another packet.
    send_pkt(0, PORT_ID, 0, 0, 0);
    send_pkt(3, PORT_ID, 0, 0, 0);
    drain(200);

    // Downstream stall long enough to trip the watchdog.
    rdy_mode = 2;
    cyc();
    max_gap = 0;
    send_pkt(8, PORT_ID, 0, 0, 1);
    repeat (40) cyc();
    rdy_mode = 0;
    drain(200);
    check("stall_gap", max_gap, TIMEOUT);

    // Randomized traffic with FIFO gaps and downstream backpressure.
    max_gap = 0;
    avail_mode = 1;
    rdy_mode = 1;
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 4; k++) begin
        logic [1:0] a;
        a = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : PORT_ID;
        send_pkt($urandom_range(0, 12), a, ($urandom_range(0, 3) == 0), 0, 0);
      end
      drain(2000);
    end
    check("rand_gap_bound", max_gap <= TIMEOUT, 1);
    avail_mode = 0;
    rdy_mode = 0;

    // Reset in the middle of a payload, then a fresh packet.
    send_pkt(6, PORT_ID, 0, 0, 0);
    repeat (5) cyc();
    rst = 1'b0;
    fifo_q.delete();
    exp_b.delete();
    exp_r.delete();
    vld_out = 1'b0;
    gap = 0;
    #1;
    check_reset_outputs("mid_reset");
    repeat (3) cyc();
    @(negedge clk);
    rst = 1'b1;
    cyc();
    send_pkt(4, PORT_ID, 0, 0, 0);
    drain(200);

    check("leftover", exp_b.size() + exp_r.size() + fifo_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
